uart_param_transceiver: RTL and testbench
=========================================

Name: uart_param_transceiver

Overview:
Parametrised full-duplex UART transmitter and receiver. Data width, parity mode, stop-bit count, bit period and synchroniser depth are all configurable. The Rx path has mid-bit sampling, false-start rejection, and per-frame parity and framing error flags. An internal loopback mux routes Tx to Rx for self-test without external wiring. It replaces the fixed 8-bit, even-parity UART core as the serial endpoint of the design.

Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits sent by Tx, 1 or 2. Rx checks the first stop bit only.
- CLOCKS_PER_BIT, 16: clk cycles per bit. Even, at least 4.
- NUM_SYNC, 3: synchroniser flops on the Rx input, at least 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset. Logic is reset on any rising clk edge where reset==0.
- tx_enable  in  1  request to send tx_data. Accepted only when tx_busy==0.
- tx_data  in  DATA_WIDTH  word to send, captured in the accept cycle.
- tx_busy  out  1  Tx frame in progress.
- serial_out  out  1  Tx line, idles high.
- serial_in  in  1  external Rx line, asynchronous.
- loopback  in  1  1 = Rx input is serial_out internally; 0 = Rx input is serial_in.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_error  out  1  one-cycle pulse with rx_valid on parity mismatch.
- rx_frame_error  out  1  one-cycle pulse with rx_valid when the stop bit is sampled low.

Behaviour:
- Reset values:
  - serial_out=1, tx_busy=0.
  - rx_valid, rx_parity_error, rx_frame_error = 0; rx_data=0.
  - All synchroniser flops = 1; Tx and Rx FSMs in IDLE; bit and cycle counters = 0.
- Frame length:
  - P = (PARITY_MODE != 0).
  - F = 1 + DATA_WIDTH + P + STOP_BITS bits.
  - Parity bit: even = ^data, odd = ~^data.
- Tx FSM (IDLE, START, DATA, PARITY, STOP):
  - Accept cycle T: tx_enable==1 && tx_busy==0. tx_data is latched into the shift register.
  - tx_busy=1 from T+1 through T+F*CLOCKS_PER_BIT inclusive.
  - Start bit drives serial_out=0 beginning at T+1.
  - Each bit is held exactly CLOCKS_PER_BIT cycles. PARITY state is skipped when P=0.
  - tx_enable while tx_busy==1 is ignored; the latched data does not change.
  - Back-to-back: tx_enable in the first cycle tx_busy==0 is accepted. No idle-bit gap is inserted beyond the stop bits.
- Rx path:
  - The selected input passes through NUM_SYNC flops before reaching the FSM.
  - Rx FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised line low → START, cycle counter cleared.
  - START: line sampled at cycle CLOCKS_PER_BIT/2 - 1.
    - Sample high: false start, return to IDLE. No flags.
    - Sample low: continue.
  - Data, parity and stop bits are each sampled CLOCKS_PER_BIT cycles after the previous sample, i.e. mid-bit.
  - Data bits are shifted in LSB first. PARITY state is skipped when P=0.
  - STOP sample cycle, all in the same cycle:
    - rx_data is updated;
    - rx_valid=1;
    - error flags are set for this frame (a stop sample of 0 sets rx_frame_error);
    - the FSM returns to IDLE.
  - rx_data is updated even when an error flag is set, and holds until the next completed frame.
- Loopback latency: rx_valid asserts at T + 1 + NUM_SYNC + (1+DATA_WIDTH+P)*CLOCKS_PER_BIT + CLOCKS_PER_BIT/2. The defaults give T+172.
- Simultaneous events: Tx and Rx are fully independent. A Tx accept in the same cycle as rx_valid is legal.
- Reset mid-frame:
  - Both FSMs abort immediately; serial_out=1 on the next edge.
  - No rx_valid is produced for the aborted frame.
  - A new tx_enable is accepted in the first cycle after reset is released.
- loopback change while Rx is not IDLE:
  - The received frame content is undefined.
  - Rx must return to IDLE within F*CLOCKS_PER_BIT cycles. No lock-up.
- Counters must not wrap inside a bit. Bit index width is $clog2(DATA_WIDTH+1).

Test Plan:
- Defaults, loopback=1, send tx_data=0xA5 at T → serial_out low at T+1. Parity bit 0. tx_busy falls after T+176. rx_valid at T+172 with rx_data=0xA5 and both error flags 0.
- loopback=0, drive serial_in with frame 0x3C and parity bit 1 → rx_valid, rx_data=0x3C, rx_parity_error=1, rx_frame_error=0.
- loopback=0, frame 0x81 with stop bit 0 → rx_valid, rx_data=0x81, rx_frame_error=1.
- serial_in low for 4 cycles, then high → no rx_valid within 200 cycles. Rx is back in IDLE and a following valid frame 0x55 is received correctly.
- Back-to-back: send 0x12, then 0x34 the first cycle tx_busy==0. Pulse tx_enable mid-frame with 0xFF → the second frame starts exactly at the end of the first frame's stop bit, 0xFF is never sent, and rx receives 0x12 then 0x34.
- DATA_WIDTH=7, PARITY_MODE=2, STOP_BITS=2, loopback, send 0x00 → odd parity bit 1, tx_busy for 176 cycles, rx_data=0x00 with no errors. Assert reset (reset=0) at cycle 50 of a second frame → serial_out=1 next edge and no rx_valid.

Source files
------------

// File: rtl/uart_param_transceiver.sv
// uart_param_transceiver
//   Full-duplex UART with independent Tx and Rx state machines. You can set the
//   data width (5..9, LSB first), the parity mode (none/even/odd), the Tx stop-bit
//   count (1 or 2), the bit period in clk cycles, and the Rx synchroniser depth.
//   The Rx path samples each bit in its middle, rejects false starts, and flags
//   parity and framing errors for each frame. A loopback mux can feed serial_out
//   back into the Rx synchroniser for self-test.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-low
//   tx_enable       : send request, accepted only while tx_busy == 0
//   tx_data         : word to send, captured in the accept cycle
//   tx_busy         : a Tx frame is in progress
//   serial_out      : Tx line, idles high
//   serial_in       : external Rx line (asynchronous)
//   loopback        : 1 = Rx listens to serial_out, 0 = Rx listens to serial_in
//   rx_data         : last received word
//   rx_valid        : one-cycle pulse when a frame completes
//   rx_parity_error : pulses with rx_valid when the parity bit does not match
//   rx_frame_error  : pulses with rx_valid when the stop bit is sampled low
module uart_param_transceiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 1,
  parameter int STOP_BITS      = 1,
  parameter int CLOCKS_PER_BIT = 16,
  parameter int NUM_SYNC       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  input  logic                  loopback,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_error,
  output logic                  rx_frame_error
);

  localparam bit HAS_PARITY = (PARITY_MODE != 0);
  localparam int CNT_W      = $clog2(CLOCKS_PER_BIT);
  localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
    if (PARITY_MODE == 2) return ~^d;
    return ^d;
  endfunction

  // ---------------------------------------------------------------- Tx path
  state_t                tx_state, tx_state_nxt;
  logic [CNT_W-1:0]      tx_cnt;
  logic [BIT_W-1:0]      tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic                  tx_accept;
  logic                  tx_bit_end;

  assign tx_accept  = (tx_state == S_IDLE) && tx_enable;
  assign tx_bit_end = (tx_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) tx_state <= S_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_enable) tx_state_nxt = S_START;
      S_START:  if (tx_bit_end) tx_state_nxt = S_DATA;
      S_DATA:   if (tx_bit_end && (tx_bit == DATA_LAST))
                  tx_state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_state_nxt = S_STOP;
      S_STOP:   if (tx_bit_end && (tx_bit == STOP_LAST)) tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  // The bit index counts data bits in DATA and stop bits in STOP. It restarts
  // whenever the state changes.
  always_ff @(posedge clk) begin
    if (!reset || (tx_state == S_IDLE)) begin
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      tx_bit <= (tx_state_nxt != tx_state) ? '0 : tx_bit + 1'b1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) begin
      tx_shift <= tx_data;
      tx_par   <= parity_of(tx_data);
    end else if ((tx_state == S_DATA) && tx_bit_end) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  always_comb begin
    serial_out = 1'b1;
    case (tx_state)
      S_START:  serial_out = 1'b0;
      S_DATA:   serial_out = tx_shift[0];
      S_PARITY: serial_out = tx_par;
      default:  serial_out = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != S_IDLE);

  // ---------------------------------------------------------------- Rx synchroniser
  logic [NUM_SYNC-1:0] sync_q;
  logic                rx_line;

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[NUM_SYNC-2:0], loopback ? serial_out : serial_in};
  end

  assign rx_line = sync_q[NUM_SYNC-1];

  // ---------------------------------------------------------------- Rx path
  state_t                rx_state, rx_state_nxt;
  logic [CNT_W-1:0]      rx_cnt;
  logic [BIT_W-1:0]      rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_par_q;
  logic                  rx_sample;

  // The start bit is sampled half a bit after the falling edge. Every later
  // sample is one full bit after the previous one, so it falls mid-bit.
  assign rx_sample = (rx_state == S_START) ? (rx_cnt == CNT_MID) : (rx_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) rx_state <= S_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (!rx_line) rx_state_nxt = S_START;
      S_START:  if (rx_sample) rx_state_nxt = rx_line ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && (rx_bit == DATA_LAST))
                  rx_state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) rx_state_nxt = S_STOP;
      S_STOP:   if (rx_sample) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || (rx_state == S_IDLE)) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      rx_cnt <= rx_sample ? '0 : rx_cnt + 1'b1;
      if ((rx_state == S_DATA) && rx_sample) rx_bit <= rx_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((rx_state == S_DATA) && rx_sample) rx_shift <= {rx_line, rx_shift[DATA_WIDTH-1:1]};
    if ((rx_state == S_PARITY) && rx_sample) rx_par_q <= rx_line;
  end

  always_ff @(posedge clk) begin
    if (!reset)        rx_data_q <= '0;
    else if (rx_valid) rx_data_q <= rx_shift;
  end

  // The completion outputs are decoded in the stop-sample cycle itself. rx_data
  // shows the new word in that same cycle and keeps it afterwards.
  always_comb begin
    rx_valid        = reset && (rx_state == S_STOP) && rx_sample;
    rx_data         = rx_valid ? rx_shift : rx_data_q;
    rx_parity_error = rx_valid && HAS_PARITY && (rx_par_q != parity_of(rx_shift));
    rx_frame_error  = rx_valid && !rx_line;
  end

endmodule

// File: tb/tb_uart_param_transceiver.sv
module tb_uart_param_transceiver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration
  logic       reset, tx_enable, serial_in, loopback;
  logic [7:0] tx_data, rx_data;
  logic       tx_busy, serial_out, rx_valid, rx_parity_error, rx_frame_error;

  // DATA_WIDTH=7, odd parity, two stop bits
  logic       reset2, tx_enable2, serial_in2, loopback2;
  logic [6:0] tx_data2, rx_data2;
  logic       tx_busy2, serial_out2, rx_valid2, rx_parity_error2, rx_frame_error2;

  uart_param_transceiver dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_data(tx_data),
    .tx_busy(tx_busy), .serial_out(serial_out), .serial_in(serial_in),
    .loopback(loopback), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_error(rx_parity_error), .rx_frame_error(rx_frame_error)
  );

  uart_param_transceiver #(.DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2),
                           .CLOCKS_PER_BIT(16), .NUM_SYNC(3)) dut2 (
    .clk(clk), .reset(reset2), .tx_enable(tx_enable2), .tx_data(tx_data2),
    .tx_busy(tx_busy2), .serial_out(serial_out2), .serial_in(serial_in2),
    .loopback(loopback2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_parity_error(rx_parity_error2), .rx_frame_error(rx_frame_error2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // record of rx_valid pulses seen by tick()
  int         n_valid, n_valid2;
  logic [7:0] v_data [4];
  logic       v_perr [4];
  logic       v_ferr [4];
  int         v_cyc  [4];
  logic [6:0] v2_data;
  logic       v2_perr, v2_ferr;
  int         v2_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid === 1'b1) begin
      if (n_valid < 4) begin
        v_data[n_valid] = rx_data;
        v_perr[n_valid] = rx_parity_error;
        v_ferr[n_valid] = rx_frame_error;
        v_cyc[n_valid]  = cyc;
      end
      n_valid++;
    end
    if (rx_valid2 === 1'b1) begin
      v2_data = rx_data2;
      v2_perr = rx_parity_error2;
      v2_ferr = rx_frame_error2;
      v2_cyc  = cyc;
      n_valid2++;
    end
  endtask

  // bits[0] is sent first; each bit is held for 16 clocks
  task automatic drive_frame(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      repeat (16) tick();
    end
    serial_in = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset2 = 1'b0;
    tx_enable = 1'b0; tx_data = '0; serial_in = 1'b1; loopback = 1'b0;
    tx_enable2 = 1'b0; tx_data2 = '0; serial_in2 = 1'b1; loopback2 = 1'b1;
    n_valid = 0; n_valid2 = 0;
    repeat (3) tick();
    vectors++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tx: serial_out=%b tx_busy=%b required 1 0", serial_out, tx_busy);
    end
    vectors++;
    if (rx_valid !== 1'b0 || rx_parity_error !== 1'b0 || rx_frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rx_flags: %b%b%b required 000", rx_valid, rx_parity_error, rx_frame_error);
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    vectors++;
    if (serial_out2 !== 1'b1 || tx_busy2 !== 1'b0 || rx_data2 !== 7'h00) begin
      miscompares++;
      $display("FAIL reset_cfg2: serial_out=%b busy=%b rx_data=%h required 1 0 00",
               serial_out2, tx_busy2, rx_data2);
    end
    reset = 1'b1; reset2 = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_loopback_a5();
    logic [7:0] d;
    int t0, j;
    d = 8'hA5;
    loopback = 1'b1; n_valid = 0;
    tx_data = d; tx_enable = 1'b1; t0 = cyc;
    tick();
    tx_enable = 1'b0;
    vectors++;
    if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL a5_start: serial_out=%b tx_busy=%b required 0 1", serial_out, tx_busy);
    end
    for (int c = 2; c <= 200; c++) begin
      tick();
      if (c >= 25 && c <= 137 && ((c - 25) % 16) == 0) begin
        j = (c - 25) / 16;
        vectors++;
        if (serial_out !== d[j]) begin
          miscompares++;
          $display("FAIL a5_data_bit%0d: got %b required %b", j, serial_out, d[j]);
        end
      end
      if (c == 153) begin
        vectors++;
        if (serial_out !== 1'b0) begin
          miscompares++;
          $display("FAIL a5_parity_bit: got %b required 0", serial_out);
        end
      end
      if (c == 169) begin
        vectors++;
        if (serial_out !== 1'b1) begin
          miscompares++;
          $display("FAIL a5_stop_bit: got %b required 1", serial_out);
        end
      end
      if (c == 176) begin
        vectors++;
        if (tx_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL a5_busy_last: got %b required 1", tx_busy);
        end
      end
      if (c == 177) begin
        vectors++;
        if (tx_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL a5_busy_fall: got %b required 0", tx_busy);
        end
      end
    end
    vectors++;
    if (n_valid !== 1 || v_cyc[0] - t0 !== 172) begin
      miscompares++;
      $display("FAIL a5_rx_valid: count=%0d at T+%0d required 1 at T+172", n_valid, v_cyc[0] - t0);
    end
    vectors++;
    if (v_data[0] !== 8'hA5 || v_perr[0] !== 1'b0 || v_ferr[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_rx_word: data=%h perr=%b ferr=%b required a5 0 0", v_data[0], v_perr[0], v_ferr[0]);
    end
    vectors++;
    if (rx_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_rx_hold: got %h required a5", rx_data);
    end
  endtask

  task automatic test_parity_error();
    loopback = 1'b0; n_valid = 0;
    drive_frame({1'b1, 1'b1, 8'h3C, 1'b0});
    repeat (40) tick();
    vectors++;
    if (n_valid !== 1 || v_data[0] !== 8'h3C || v_perr[0] !== 1'b1 || v_ferr[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_err: count=%0d data=%h perr=%b ferr=%b required 1 3c 1 0",
               n_valid, v_data[0], v_perr[0], v_ferr[0]);
    end
  endtask

  task automatic test_frame_error();
    n_valid = 0;
    drive_frame({1'b0, 1'b0, 8'h81, 1'b0});
    repeat (60) tick();
    vectors++;
    if (n_valid !== 1 || v_data[0] !== 8'h81 || v_perr[0] !== 1'b0 || v_ferr[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err: count=%0d data=%h perr=%b ferr=%b required 1 81 0 1",
               n_valid, v_data[0], v_perr[0], v_ferr[0]);
    end
  endtask

  task automatic test_false_start();
    n_valid = 0;
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    repeat (200) tick();
    vectors++;
    if (n_valid !== 0) begin
      miscompares++;
      $display("FAIL false_start: %0d rx_valid pulses required 0", n_valid);
    end
    drive_frame({1'b1, 1'b0, 8'h55, 1'b0});
    repeat (40) tick();
    vectors++;
    if (n_valid !== 1 || v_data[0] !== 8'h55 || v_perr[0] !== 1'b0 || v_ferr[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL after_false_start: count=%0d data=%h perr=%b ferr=%b required 1 55 0 0",
               n_valid, v_data[0], v_perr[0], v_ferr[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0, acc2;
    loopback = 1'b1; n_valid = 0; acc2 = 0;
    tx_data = 8'h12; tx_enable = 1'b1; t0 = cyc;
    for (int c = 1; c <= 380; c++) begin
      tick();
      tx_enable = 1'b0;
      if (acc2 != 0 && c == acc2 + 1) begin
        vectors++;
        if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_second_start: serial_out=%b busy=%b required 0 1", serial_out, tx_busy);
        end
      end
      if (c == 80) begin
        tx_data = 8'hFF; tx_enable = 1'b1;
      end
      if (acc2 == 0 && tx_busy === 1'b0) begin
        acc2 = c; tx_data = 8'h34; tx_enable = 1'b1;
      end
    end
    vectors++;
    if (acc2 !== 177) begin
      miscompares++;
      $display("FAIL b2b_first_idle: busy fell at T+%0d required T+177", acc2);
    end
    vectors++;
    if (n_valid !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: %0d frames required 2", n_valid);
    end
    vectors++;
    if (v_data[0] !== 8'h12 || v_data[1] !== 8'h34 || v_perr[1] !== 1'b0 || v_ferr[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_words: %h %h perr=%b ferr=%b required 12 34 0 0",
               v_data[0], v_data[1], v_perr[1], v_ferr[1]);
    end
    vectors++;
    if (v_cyc[1] - t0 !== 349) begin
      miscompares++;
      $display("FAIL b2b_second_valid: at T+%0d required T+349", v_cyc[1] - t0);
    end
  endtask

  task automatic test_cfg2();
    int t0;
    n_valid2 = 0;
    tx_data2 = 7'h00; tx_enable2 = 1'b1; t0 = cyc;
    for (int c = 1; c <= 200; c++) begin
      tick();
      tx_enable2 = 1'b0;
      if (c == 137) begin
        vectors++;
        if (serial_out2 !== 1'b1) begin
          miscompares++;
          $display("FAIL cfg2_odd_parity: got %b required 1", serial_out2);
        end
      end
      if (c == 176 || c == 177) begin
        vectors++;
        if (tx_busy2 !== (c == 176)) begin
          miscompares++;
          $display("FAIL cfg2_busy_T+%0d: got %b required %b", c, tx_busy2, (c == 176));
        end
      end
    end
    vectors++;
    if (n_valid2 !== 1 || v2_cyc - t0 !== 156 || v2_data !== 7'h00 || v2_perr !== 1'b0 || v2_ferr !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg2_rx: count=%0d at T+%0d data=%h perr=%b ferr=%b required 1 T+156 00 0 0",
               n_valid2, v2_cyc - t0, v2_data, v2_perr, v2_ferr);
    end
    // second frame, aborted by reset in its 50th cycle
    n_valid2 = 0;
    tx_data2 = 7'h00; tx_enable2 = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      tx_enable2 = 1'b0;
    end
    reset2 = 1'b0;
    tick();
    vectors++;
    if (serial_out2 !== 1'b1 || tx_busy2 !== 1'b0 || rx_valid2 !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg2_abort: serial_out=%b busy=%b rx_valid=%b required 1 0 0",
               serial_out2, tx_busy2, rx_valid2);
    end
    reset2 = 1'b1;
    tx_data2 = 7'h2A; tx_enable2 = 1'b1;
    tick();
    tx_enable2 = 1'b0;
    vectors++;
    if (tx_busy2 !== 1'b1 || serial_out2 !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg2_accept_after_reset: busy=%b serial_out=%b required 1 0", tx_busy2, serial_out2);
    end
    repeat (200) tick();
    vectors++;
    if (n_valid2 !== 1 || v2_data !== 7'h2A || v2_perr !== 1'b0 || v2_ferr !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg2_after_abort: count=%0d data=%h perr=%b ferr=%b required 1 2a 0 0",
               n_valid2, v2_data, v2_perr, v2_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_parity_error();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_cfg2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
